// File: rtl/m_imem_loader_pkg.sv
// Shared types and constants for the UART program loader (m_imem_loader / m_uart_rx).
// LOADER_CKSUM_EN adds the trailing checksum byte and its S_CKSUM state.
package m_imem_loader_pkg;

    localparam int unsigned DEF_CLKS_PER_BIT = 434;
    localparam int unsigned DEF_ADDR_W       = 12;
    localparam int unsigned BYTE_W           = 8;
    localparam int unsigned WORD_W           = 32;
    localparam int unsigned LEN_W            = 16;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

`ifdef LOADER_CKSUM_EN
    typedef enum logic [2:0] {
        S_SYNC  = 3'd0,
        S_LEN_H = 3'd1,
        S_LEN_L = 3'd2,
        S_DATA  = 3'd3,
        S_CKSUM = 3'd4,
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
    } loader_state_t;
`else
    typedef enum logic [2:0] {
        S_SYNC  = 3'd0,
        S_LEN_H = 3'd1,
        S_LEN_L = 3'd2,
        S_DATA  = 3'd3,
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
    } loader_state_t;
`endif

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    // 8-bit modular sum used for the frame checksum.
    function automatic logic [7:0] cksum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

endpackage

// File: rtl/m_imem_loader_uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling, start-glitch rejection,
// one-cycle byte_valid or frame_err pulse per received frame.
module m_uart_rx
    import m_imem_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic       w_clk,
    input  logic       w_rst,
    input  logic       w_rxd,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned HALF  = CLKS_PER_BIT / 2;

    logic [1:0]       sync_r;
    logic             rxd_prev_r;
    rx_state_t        state_r;
    rx_state_t        next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       bit_cnt_r;
    logic             rxd_s;
    logic             fall_s;
    logic             tick_half_s;
    logic             tick_full_s;

    assign rxd_s       = sync_r[1];
    assign fall_s      = rxd_prev_r & ~rxd_s;
    assign tick_half_s = (cnt_r == CNT_W'(HALF - 1));
    assign tick_full_s = (cnt_r == CNT_W'(CLKS_PER_BIT - 1));

    // Synchroniser for the asynchronous serial line; idles high.
    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            sync_r     <= 2'b11;
            rxd_prev_r <= 1'b1;
        end else begin
            sync_r     <= {sync_r[0], w_rxd};
            rxd_prev_r <= sync_r[1];
        end
    end

    // Receiver state register.
    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            state_r <= RX_IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Receiver next-state: a start bit that is high again at mid-point is a glitch.
    always_comb begin
        next_s = state_r;
        case (state_r)
            RX_IDLE: begin
                if (fall_s) next_s = RX_START;
                else        next_s = RX_IDLE;
            end
            RX_START: begin
                if (tick_half_s) next_s = rxd_s ? RX_IDLE : RX_DATA;
                else             next_s = RX_START;
            end
            RX_DATA: begin
                if (tick_full_s && (bit_cnt_r == 3'd7)) next_s = RX_STOP;
                else                                    next_s = RX_DATA;
            end
            RX_STOP: begin
                if (tick_full_s) next_s = RX_IDLE;
                else             next_s = RX_STOP;
            end
            default: next_s = RX_IDLE;
        endcase
    end

    // Bit timer, LSB-first shift register and registered result pulses.
    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            cnt_r      <= {CNT_W{1'b0}};
            bit_cnt_r  <= 3'd0;
            rx_byte    <= 8'd0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= (state_r == RX_STOP) && tick_full_s && rxd_s;
            frame_err  <= (state_r == RX_STOP) && tick_full_s && !rxd_s;
            if ((state_r != next_s) || (state_r == RX_IDLE)) begin
                cnt_r <= {CNT_W{1'b0}};
            end else if (tick_full_s) begin
                cnt_r <= {CNT_W{1'b0}};
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
            if (state_r == RX_START) begin
                bit_cnt_r <= 3'd0;
            end else if ((state_r == RX_DATA) && tick_full_s) begin
                bit_cnt_r <= bit_cnt_r + 3'd1;
                rx_byte   <= {rxd_s, rx_byte[7:1]};
            end
        end
    end

endmodule

// File: rtl/m_imem_loader.sv
// UART program loader: parses A5 / LEN_H / LEN_L / data [/ checksum] frames into
// big-endian word writes and holds the processor in reset until loaded. Option: LOADER_CKSUM_EN.
module m_imem_loader
    import m_imem_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int unsigned ADDR_W       = DEF_ADDR_W
) (
    input  logic              w_clk,
    input  logic              w_rst,
    input  logic              w_rxd,
    output logic              r_we,
    output logic [ADDR_W-1:0] r_addr,
    output logic [31:0]       r_wdata,
    output logic              r_busy,
    output logic              r_done,
    output logic              r_err
);

    localparam logic [LEN_W:0] MAX_WORDS = (LEN_W + 1)'(2 ** ADDR_W);

    logic [7:0]       rx_byte_s;
    logic             byte_valid_s;
    logic             frame_err_s;
    loader_state_t    state_r;
    loader_state_t    next_s;
    logic [7:0]       len_h_r;
    logic [LEN_W-1:0] len_r;
    logic [1:0]       bcnt_r;
    logic [LEN_W-1:0] len_s;
    logic             len_bad_s;
    logic [LEN_W:0]   idx_next_s;
    logic             last_word_s;
    logic             busy_s;
    logic             done_s;
    logic             err_s;

    m_uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .w_clk     (w_clk),
        .w_rst     (w_rst),
        .w_rxd     (w_rxd),
        .rx_byte   (rx_byte_s),
        .byte_valid(byte_valid_s),
        .frame_err (frame_err_s)
    );

    assign len_s       = {len_h_r, rx_byte_s};
    assign len_bad_s   = (len_s == 16'd0) || ({1'b0, len_s} > MAX_WORDS);
    assign idx_next_s  = (LEN_W + 1)'(r_addr) + (LEN_W + 1)'(1);
    assign last_word_s = (idx_next_s == {1'b0, len_r});

`ifdef LOADER_CKSUM_EN
    logic [7:0] cksum_r;

    // Running sum of length and data bytes, restarted by each sync byte.
    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            cksum_r <= 8'd0;
        end else if (byte_valid_s) begin
            case (state_r)
                S_SYNC, S_DONE, S_ERR: if (rx_byte_s == SYNC_BYTE) cksum_r <= 8'd0;
                S_LEN_H, S_LEN_L, S_DATA: cksum_r <= cksum_add(cksum_r, rx_byte_s);
                default: cksum_r <= cksum_r;
            endcase
        end
    end
`endif

    // Loader state register with registered status outputs.
    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            state_r <= S_SYNC;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            state_r <= next_s;
            r_busy  <= busy_s;
            r_done  <= done_s;
            r_err   <= err_s;
        end
    end

    // Loader next-state; a framing error mid-frame aborts the load.
    always_comb begin
        next_s = state_r;
        case (state_r)
            S_SYNC, S_DONE, S_ERR: begin
                if (byte_valid_s && (rx_byte_s == SYNC_BYTE)) next_s = S_LEN_H;
                else                                          next_s = state_r;
            end
            S_LEN_H: begin
                if (frame_err_s)       next_s = S_ERR;
                else if (byte_valid_s) next_s = S_LEN_L;
                else                   next_s = S_LEN_H;
            end
            S_LEN_L: begin
                if (frame_err_s)       next_s = S_ERR;
                else if (byte_valid_s) next_s = len_bad_s ? S_ERR : S_DATA;
                else                   next_s = S_LEN_L;
            end
            S_DATA: begin
                if (frame_err_s) begin
                    next_s = S_ERR;
                end else if (r_we && last_word_s) begin
`ifdef LOADER_CKSUM_EN
                    next_s = S_CKSUM;
`else
                    next_s = S_DONE;
`endif
                end else begin
                    next_s = S_DATA;
                end
            end
`ifdef LOADER_CKSUM_EN
            S_CKSUM: begin
                if (frame_err_s)       next_s = S_ERR;
                else if (byte_valid_s) next_s = (rx_byte_s == cksum_r) ? S_DONE : S_ERR;
                else                   next_s = S_CKSUM;
            end
`endif
            default: next_s = S_SYNC;
        endcase
    end

    // Status decode from the upcoming state so outputs line up with state_r.
    always_comb begin
        busy_s = 1'b1;
        done_s = 1'b0;
        err_s  = 1'b0;
        case (next_s)
            S_DONE: begin
                busy_s = 1'b0;
                done_s = 1'b1;
            end
            S_ERR:   err_s = 1'b1;
            default: busy_s = 1'b1;
        endcase
    end

    // Word assembly, write strobe and word index.
    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            r_we    <= 1'b0;
            r_addr  <= {ADDR_W{1'b0}};
            r_wdata <= 32'd0;
            len_h_r <= 8'd0;
            len_r   <= 16'd0;
            bcnt_r  <= 2'd0;
        end else begin
            r_we <= 1'b0;
            case (state_r)
                S_SYNC, S_DONE, S_ERR: begin
                    if (byte_valid_s && (rx_byte_s == SYNC_BYTE)) begin
                        r_addr <= {ADDR_W{1'b0}};
                        bcnt_r <= 2'd0;
                    end
                end
                S_LEN_H: if (byte_valid_s) len_h_r <= rx_byte_s;
                S_LEN_L: if (byte_valid_s) len_r <= len_s;
                S_DATA: begin
                    if (byte_valid_s) begin
                        r_wdata <= {r_wdata[23:0], rx_byte_s};
                        bcnt_r  <= bcnt_r + 2'd1;
                        r_we    <= (bcnt_r == 2'd3);
                    end
                    if (r_we) r_addr <= r_addr + ADDR_W'(1);
                end
                default: r_we <= 1'b0;
            endcase
        end
    end

endmodule
